// File: rtl/inst_rom_arb_if.sv
// ============================================================================
// Module   : inst_rom_arb_if
// Brief    : Fetch/debug request ports and ROM port bundle for inst_rom_arb.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface inst_rom_arb_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;

  logic        dbg_req;
  logic [31:0] dbg_addr;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        dbg_err;

  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;

  // slave = the arbiter, master = requesters plus ROM
  modport slave (
    input  if_req, if_addr, if_flush, dbg_req, dbg_addr, rom_inst,
    output if_gnt, if_rvalid, if_rdata, if_err,
    output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
    output rom_ce, rom_addr
  );

  modport master (
    output if_req, if_addr, if_flush, dbg_req, dbg_addr, rom_inst,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
    input  rom_ce, rom_addr
  );
endinterface

`default_nettype wire

// File: rtl/inst_rom_arb.sv
// ============================================================================
// Module   : inst_rom_arb
// Brief    : Two-port (fetch/debug) arbiter in front of a combinational ROM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_rom_arb #(
  parameter int DBG_MAX_WAIT = 4,
  parameter int ADDR_HI      = 10
) (
  input  wire logic    clk,
  input  wire logic    rst,
  inst_rom_arb_if.slave bus
);

  localparam logic [3:0] c_dbg_max = 4'(DBG_MAX_WAIT);

  generate
    if (DBG_MAX_WAIT < 1 || DBG_MAX_WAIT > 15) begin : g_bad_wait
      $error("inst_rom_arb: DBG_MAX_WAIT out of range 1..15");
    end
    if (ADDR_HI < 2 || ADDR_HI > 31) begin : g_bad_addr_hi
      $error("inst_rom_arb: ADDR_HI out of range 2..31");
    end
  endgenerate

  typedef enum logic [0:0] {
    ARB_IF  = 1'b0,
    ARB_DBG = 1'b1
  } arb_state_t;

  arb_state_t  r_state, w_state_nxt;
  logic [3:0]  r_wait_cnt, w_wait_cnt_nxt;
  logic        w_if_gnt, w_dbg_gnt;
  logic        w_if_mis, w_dbg_mis;

  logic        r_if_rvalid, r_if_err, r_dbg_rvalid, r_dbg_err;
  logic [31:0] r_if_rdata, r_dbg_rdata;

  assign w_if_mis  = (bus.if_addr[1:0]  != 2'b00);
  assign w_dbg_mis = (bus.dbg_addr[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ARB_IF;
      r_wait_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  always_comb begin
    w_if_gnt       = 1'b0;
    w_dbg_gnt      = 1'b0;
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;

    // Grants stay combinational during reset but are held low.
    if (rst) begin
      if (r_state == ARB_IF) begin
        w_if_gnt  = bus.if_req;
        w_dbg_gnt = bus.dbg_req & ~bus.if_req;
      end else begin
        w_dbg_gnt = bus.dbg_req;
        w_if_gnt  = bus.if_req & ~bus.dbg_req;
      end
    end

    if (bus.dbg_req && !w_dbg_gnt) begin
      if (r_wait_cnt != 4'hF) begin
        w_wait_cnt_nxt = r_wait_cnt + 4'd1;
      end
    end else begin
      w_wait_cnt_nxt = 4'd0;
    end

    case (r_state)
      ARB_IF: begin
        if (bus.dbg_req && !w_dbg_gnt && (w_wait_cnt_nxt == c_dbg_max)) begin
          w_state_nxt = ARB_DBG;
        end
      end
      ARB_DBG: begin
        if (w_dbg_gnt || !bus.dbg_req) begin
          w_state_nxt = ARB_IF;
        end
      end
      default: w_state_nxt = ARB_IF;
    endcase
  end

  assign bus.if_gnt   = w_if_gnt;
  assign bus.dbg_gnt  = w_dbg_gnt;
  assign bus.rom_ce   = w_if_gnt | w_dbg_gnt;
  assign bus.rom_addr = w_if_gnt  ? bus.if_addr  :
                        w_dbg_gnt ? bus.dbg_addr : 32'h0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_rvalid  <= 1'b0;
      r_if_rdata   <= 32'h0;
      r_if_err     <= 1'b0;
      r_dbg_rvalid <= 1'b0;
      r_dbg_rdata  <= 32'h0;
      r_dbg_err    <= 1'b0;
    end else begin
      r_if_rvalid  <= w_if_gnt & ~bus.if_flush;
      r_dbg_rvalid <= w_dbg_gnt;
      if (w_if_gnt) begin
        r_if_rdata <= w_if_mis ? 32'h0 : bus.rom_inst;
        r_if_err   <= w_if_mis;
      end
      if (w_dbg_gnt) begin
        r_dbg_rdata <= w_dbg_mis ? 32'h0 : bus.rom_inst;
        r_dbg_err   <= w_dbg_mis;
      end
    end
  end

  // A flush arriving in the response cycle kills the pulse but not the data.
  assign bus.if_rvalid  = r_if_rvalid & ~bus.if_flush;
  assign bus.if_rdata   = r_if_rdata;
  assign bus.if_err     = r_if_err;
  assign bus.dbg_rvalid = r_dbg_rvalid;
  assign bus.dbg_rdata  = r_dbg_rdata;
  assign bus.dbg_err    = r_dbg_err;

endmodule

`default_nettype wire

// File: tb/tb_inst_rom_arb.sv
// ============================================================================
// Module   : tb_inst_rom_arb
// Brief    : Directed, scoreboard-based bench for inst_rom_arb.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_rom_arb;

  localparam int ADDR_HI = 10;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  inst_rom_arb_if bus ();

  inst_rom_arb #(.DBG_MAX_WAIT(4), .ADDR_HI(ADDR_HI)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [ADDR_HI-2:0] idx);
    return (idx == 2) ? 32'h34011100 : (32'hC0DE0000 | 32'(idx));
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return (a[1:0] != 2'b00) ? 32'h0 : rom_word(a[ADDR_HI:2]);
  endfunction

  always_comb bus.rom_inst = bus.rom_ce ? rom_word(bus.rom_addr[ADDR_HI:2]) : 32'h0;

  typedef struct {
    logic        ifv;
    logic        ifk;
    logic [31:0] ifd;
    logic        ife;
    logic        dv;
    logic [31:0] dd;
    logic        de;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] m_ifd, m_dd;
  logic        m_ife, m_ifk, m_de;

  task automatic chk(input string tag, input string what,
                     input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
    end
  endtask

  function automatic sb_t idle_entry();
    sb_t e;
    e.ifv = 1'b0; e.ifk = m_ifk; e.ifd = m_ifd; e.ife = m_ife;
    e.dv  = 1'b0; e.dd  = m_dd;  e.de  = m_de;
    return e;
  endfunction

  // One cycle: drive, check the response due now and the grants, queue next response.
  task automatic step(input logic ir, input logic [31:0] ia, input logic fl,
                      input logic dr, input logic [31:0] da,
                      input logic eig, input logic edg, input string tag);
    sb_t e;
    sb_t n;
    #1;
    bus.if_req = ir; bus.if_addr = ia; bus.if_flush = fl;
    bus.dbg_req = dr; bus.dbg_addr = da;
    #1;
    if (sb.size() == 0) begin
      tests++; fails++;
      $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk(tag, "if_rvalid", 32'(bus.if_rvalid), 32'(e.ifv & ~fl));
      if (e.ifk) begin
        chk(tag, "if_rdata", bus.if_rdata, e.ifd);
        chk(tag, "if_err", 32'(bus.if_err), 32'(e.ife));
      end
      chk(tag, "dbg_rvalid", 32'(bus.dbg_rvalid), 32'(e.dv));
      chk(tag, "dbg_rdata", bus.dbg_rdata, e.dd);
      chk(tag, "dbg_err", 32'(bus.dbg_err), 32'(e.de));
    end
    chk(tag, "if_gnt", 32'(bus.if_gnt), 32'(eig));
    chk(tag, "dbg_gnt", 32'(bus.dbg_gnt), 32'(edg));
    chk(tag, "rom_ce", 32'(bus.rom_ce), 32'(eig | edg));
    chk(tag, "rom_addr", bus.rom_addr, eig ? ia : (edg ? da : 32'h0));
    if (eig) begin
      m_ifd = exp_word(ia); m_ife = (ia[1:0] != 2'b00); m_ifk = ~fl;
    end
    if (edg) begin
      m_dd = exp_word(da); m_de = (da[1:0] != 2'b00);
    end
    n = idle_entry();
    n.ifv = eig & ~fl;
    n.dv  = edg;
    sb.push_back(n);
    @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    sb_t e;
    tests = 0; fails = 0;
    m_ifd = 32'h0; m_ife = 1'b0; m_ifk = 1'b1;
    m_dd  = 32'h0; m_de  = 1'b0;

    // Reset with requests present: grants must be held low.
    rst = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h8; bus.if_flush = 1'b0;
    bus.dbg_req = 1'b1; bus.dbg_addr = 32'h4;
    #2;
    chk("reset", "if_gnt", 32'(bus.if_gnt), 32'h0);
    chk("reset", "dbg_gnt", 32'(bus.dbg_gnt), 32'h0);
    chk("reset", "rom_ce", 32'(bus.rom_ce), 32'h0);
    chk("reset", "if_rvalid", 32'(bus.if_rvalid), 32'h0);
    chk("reset", "if_rdata", bus.if_rdata, 32'h0);
    chk("reset", "dbg_rvalid", 32'(bus.dbg_rvalid), 32'h0);
    chk("reset", "dbg_rdata", bus.dbg_rdata, 32'h0);
    bus.if_req = 1'b0; bus.dbg_req = 1'b0;
    #4 rst = 1'b1;
    sb.push_back(idle_entry());
    @(posedge clk);

    step(0, 32'h0, 0, 0, 32'h0, 0, 0, "idle0");
    step(1, 32'h8, 0, 0, 32'h0, 1, 0, "fetch8");
    step(0, 32'h0, 0, 0, 32'h0, 0, 0, "fetch8_rsp");

    // Continuous contention: debug wins every fifth cycle.
    for (int i = 0; i < 10; i++)
      step(1, 32'h10 + 32'(4*i), 0, 1, 32'h200 + 32'(4*i),
           (i % 5) != 4, (i % 5) == 4, $sformatf("cont%0d", i));
    step(0, 32'h0, 0, 0, 32'h0, 0, 0, "cont_rsp");

    step(0, 32'h0, 0, 1, 32'h6, 0, 1, "mis_dbg");
    step(0, 32'h0, 0, 0, 32'h0, 0, 0, "mis_rsp");
    step(0, 32'h0, 0, 0, 32'h0, 0, 0, "mis_hold");
    step(1, 32'h2A, 0, 0, 32'h0, 1, 0, "mis_if");
    step(0, 32'h0, 0, 0, 32'h0, 0, 0, "mis_if_rsp");

    // Flush with the grant, then a clean fetch, then flush in the response cycle.
    step(1, 32'hC, 1, 0, 32'h0, 1, 0, "flush_n");
    step(1, 32'h10, 0, 0, 32'h0, 1, 0, "flush_n1");
    step(1, 32'h14, 0, 0, 32'h0, 1, 0, "flush_rsp");
    step(0, 32'h0, 1, 1, 32'h20, 0, 1, "flush_late");
    step(0, 32'h0, 1, 0, 32'h0, 0, 0, "flush_dbg_rsp");
    step(0, 32'h0, 0, 0, 32'h0, 0, 0, "flush_idle");

    // Reach ARB_DBG, then reset before the debug response arrives.
    for (int i = 0; i < 4; i++)
      step(1, 32'h40 + 32'(4*i), 0, 1, 32'h300, 1, 0, $sformatf("pre_rst%0d", i));
    #1;
    bus.if_req = 1'b1; bus.if_addr = 32'h50; bus.dbg_req = 1'b1; bus.dbg_addr = 32'h304;
    #1;
    e = sb.pop_front();
    chk("rst_mid", "if_rvalid_pre", 32'(bus.if_rvalid), 32'(e.ifv));
    chk("rst_mid", "dbg_gnt_pre", 32'(bus.dbg_gnt), 32'h1);
    #1 rst = 1'b0;
    #1;
    chk("rst_mid", "if_gnt", 32'(bus.if_gnt), 32'h0);
    chk("rst_mid", "dbg_gnt", 32'(bus.dbg_gnt), 32'h0);
    chk("rst_mid", "if_rvalid", 32'(bus.if_rvalid), 32'h0);
    chk("rst_mid", "if_rdata", bus.if_rdata, 32'h0);
    chk("rst_mid", "if_err", 32'(bus.if_err), 32'h0);
    chk("rst_mid", "dbg_rvalid", 32'(bus.dbg_rvalid), 32'h0);
    chk("rst_mid", "dbg_rdata", bus.dbg_rdata, 32'h0);
    chk("rst_mid", "dbg_err", 32'(bus.dbg_err), 32'h0);
    bus.if_req = 1'b0; bus.dbg_req = 1'b0;
    #1 rst = 1'b1;
    m_ifd = 32'h0; m_ife = 1'b0; m_ifk = 1'b1;
    m_dd  = 32'h0; m_de  = 1'b0;
    sb.delete();
    sb.push_back(idle_entry());
    @(posedge clk);

    step(0, 32'h0, 0, 0, 32'h0, 0, 0, "post_rst_idle");
    for (int i = 0; i < 5; i++)
      step(1, 32'h60 + 32'(4*i), 0, 1, 32'h380 + 32'(4*i),
           i != 4, i == 4, $sformatf("post_rst%0d", i));
    step(0, 32'h0, 0, 0, 32'h0, 0, 0, "final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
